mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, sitting between the execute-stage output register and write-back. It decodes the registered execute-stage controls, runs a request/acknowledge handshake to data memory for word loads and stores, stalls the front of the pipe while an access is outstanding, and resolves branches. It also drives the MEM-side forwarding sources (`mem_regD`, `RegW_en_mem`, `regFromMem`) and holds the MEM/WB register that sources the WB-side forwarding path.

## Interface
Parameters:
- `ADDR_W`, 32: data-memory address width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `EN_REG`  in  1: pipeline-advance enable from the hazard controller.
- `WB_EN_in`, `MEM_R_EN_in`, `MEM_W_EN_in`, `MEM_TO_REG_in`, `is_BRANCH_in`, `zero_in`  in  1 each: registered controls from the execute stage.
- `regD_in`  in  5: destination register.
- `alu_result`  in  32: ALU result, also the memory byte address.
- `store_data`  in  32: forwarded store data.
- `PCNEXT_in`  in  32: computed branch target.
- `dmem_req`  out  1: memory request.
- `dmem_we`  out  1: 1 = store.
- `dmem_addr`  out  ADDR_W: byte address.
- `dmem_wdata`  out  32: store data.
- `dmem_rdata`  in  32: load data, valid while `dmem_ack` is high.
- `dmem_ack`  in  1: access complete.
- `stall_mem`  out  1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `branch_taken`  out  1: high when `is_BRANCH_in` and `zero_in` are both high.
- `branch_target`  out  32: equals `PCNEXT_in`.
- `mem_regD`  out  5: forwarding source, equals `regD_in`.
- `RegW_en_mem`  out  1: forwarding source, equals `WB_EN_in`.
- `regFromMem`  out  32: forwarding source, equals `alu_result`.
- `wb_regD`  out  5: registered destination.
- `RegW_en_wb`  out  1: registered write enable.
- `regFromWB`  out  32: registered write-back data.
- `addr_err`  out  1: registered misalignment flag.

## Operation
- A memory operation is present when `MEM_R_EN_in` or `MEM_W_EN_in` is high. If both are high, the access is a store.
- The address is misaligned when `alu_result[1:0]` is nonzero. A misaligned memory operation issues no request and does not stall. It commits with `RegW_en_wb`=0 and `addr_err`=1 for one cycle.
- States:
  - IDLE: no access outstanding.
  - WAIT: request issued, ack pending.
  - DONE: ack received, waiting for `EN_REG`.
- `dmem_req` = (IDLE and aligned memory operation) or WAIT. It is forced to 0 while `reset` is low.
- While `dmem_req` is high: `dmem_we` = store, `dmem_addr` = `alu_result`, `dmem_wdata` = `store_data`. When `dmem_req` is low, these outputs are 0.
- `stall_mem` = (`dmem_req` and not `dmem_ack`).
- The upstream register is frozen by `stall_mem`, so address and data stay stable until ack.
- Transitions:
  - IDLE to WAIT: request issued and `dmem_ack`=0.
  - IDLE or WAIT to DONE: `dmem_ack`=1 and `EN_REG`=0.
  - IDLE or WAIT to IDLE: `dmem_ack`=1 and `EN_REG`=1 (commit).
  - DONE to IDLE: `EN_REG`=1 (commit).
  - DONE never re-issues the request for the same slot.
- A load captures `dmem_rdata` into an internal load buffer on the ack cycle. `dmem_ack` outside a request is ignored.
- MEM/WB commit happens on a rising edge with `EN_REG`=1 and `stall_mem`=0:
  - `wb_regD` <= `regD_in`.
  - `RegW_en_wb` <= `WB_EN_in` and not misaligned-memory-operation.
  - `regFromWB` <= (`MEM_TO_REG_in` ? load data : `alu_result`). Load data is `dmem_rdata` if the ack arrives in the same cycle, otherwise the buffer.
  - `addr_err` <= misaligned-memory-operation.
- With no commit, `addr_err` clears to 0 and the other MEM/WB outputs hold their values.
- Non-memory instructions pass through in one cycle with no stall.
- Branch and forwarding outputs are combinational from the inputs and are valid even during a stall.

## Timing
- Reset (`reset` low, asynchronous):
  - State goes to IDLE and the load buffer clears to 0.
  - `wb_regD`, `RegW_en_wb`, `regFromWB` and `addr_err` go to 0.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `stall_mem` are 0.
  - Combinational outputs follow their inputs.
- Reset mid-access: the request drops immediately and any later ack is ignored. The memory side must tolerate the abandoned access.
- Latency:
  - Zero-wait memory (ack in the request cycle): 1 cycle, no stall.
  - N wait cycles: `stall_mem` is high for N cycles and the commit happens on the ack cycle.
- Back-to-back loads: the second request is asserted combinationally in the cycle after the first commit, with no bubble.
- Ack with `EN_REG` low: the data is held in DONE, and `stall_mem` is low so the hazard controller owns the freeze.

## Test plan
- Non-memory operation: `alu_result`=0x0000_002A, `WB_EN_in`=1, `regD_in`=5, `EN_REG`=1 -> after 1 edge `regFromWB`=0x2A, `wb_regD`=5, `RegW_en_wb`=1, no `dmem_req`.
- Load at 0x100, `dmem_ack` after 3 cycles with `dmem_rdata`=0xDEAD_BEEF, `MEM_TO_REG_in`=1 -> `stall_mem` high for exactly 3 cycles, then `regFromWB`=0xDEADBEEF; `dmem_addr` is stable at 0x100 throughout.
- Store at 0x204 with `store_data`=0x1234_5678 and zero-wait ack -> `dmem_we`=1, `dmem_wdata`=0x12345678, no stall, `RegW_en_wb`=0.
- Misaligned load at 0x102 -> no `dmem_req`, `addr_err`=1 for one cycle, `RegW_en_wb`=0.
- Ack with `EN_REG`=0 for 2 cycles, then `EN_REG`=1 -> a single request is issued, and the data commits on the `EN_REG` edge.
- `reset` pulsed low during WAIT -> `dmem_req` drops immediately; all registered outputs are 0; a late ack causes no commit.
- Branch: `is_BRANCH_in`=1, `zero_in`=1, `PCNEXT_in`=0x40 -> `branch_taken`=1 and `branch_target`=0x40 in the same cycle.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of a five-stage pipeline. Decodes the
//               registered execute-stage controls and runs a req/ack
//               handshake to data memory for aligned word loads and stores.
//               It stalls the front of the pipe while an access is
//               outstanding, resolves branches, and drives the MEM-side
//               forwarding sources. It also holds the MEM/WB register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset (async, active-low)      clock and reset
//   EN_REG                              pipeline-advance enable
//   WB_EN_in .. zero_in, regD_in        registered execute-stage controls
//   alu_result, store_data, PCNEXT_in   execute-stage data
//   dmem_*                              data-memory handshake
//   stall_mem                           freeze request to the front of the pipe
//   branch_taken, branch_target         branch resolution (combinational)
//   mem_regD, RegW_en_mem, regFromMem   MEM-side forwarding (combinational)
//   wb_regD, RegW_en_wb, regFromWB      MEM/WB register
//   addr_err                            one-cycle misalignment flag
// ============================================================================
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EN_REG,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              MEM_TO_REG_in,
    input  logic              is_BRANCH_in,
    input  logic              zero_in,
    input  logic [4:0]        regD_in,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic [31:0]       PCNEXT_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_mem,
    output logic              branch_taken,
    output logic [31:0]       branch_target,
    output logic [4:0]        mem_regD,
    output logic              RegW_en_mem,
    output logic [31:0]       regFromMem,
    output logic [4:0]        wb_regD,
    output logic              RegW_en_wb,
    output logic [31:0]       regFromWB,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no access outstanding
        ST_WAIT = 2'd1,   // request issued, ack pending
        ST_DONE = 2'd2    // ack received, waiting for EN_REG to commit
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ldbuf_q, ldbuf_d;
    logic [4:0]  wb_regD_q, wb_regD_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        addr_err_q, addr_err_d;

    logic              w_mem_op;
    logic              w_store;
    logic              w_misaligned;
    logic              w_aligned_op;
    logic              w_req;
    logic              w_ack;
    logic              w_stall;
    logic              w_commit;
    logic [31:0]       w_load_data;
    logic [ADDR_W-1:0] w_addr;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_mem_op     = MEM_R_EN_in | MEM_W_EN_in;
    // Both enables set is treated as a store.
    assign w_store      = MEM_W_EN_in;
    assign w_misaligned = w_mem_op & (alu_result[1:0] != 2'b00);
    assign w_aligned_op = w_mem_op & ~w_misaligned;

    // The request is gated by reset so it drops the instant reset asserts,
    // not just at the next edge when the state register clears.
    assign w_req   = reset & (((state_q == ST_IDLE) & w_aligned_op) |
                              (state_q == ST_WAIT));
    // Acks are only meaningful while a request is on the bus.
    assign w_ack   = w_req & dmem_ack;
    assign w_stall = w_req & ~dmem_ack;

    // Commit sees the load data on the ack cycle, otherwise the buffer
    // (the DONE case, where the ack has already come and gone).
    assign w_load_data = w_ack ? dmem_rdata : ldbuf_q;
    assign w_commit    = EN_REG & ~w_stall;

    generate
        if (ADDR_W <= 32) begin : g_addr_narrow
            assign w_addr = alu_result[ADDR_W-1:0];
        end else begin : g_addr_wide
            assign w_addr = {{(ADDR_W-32){1'b0}}, alu_result};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (dmem_ack) begin
                        state_d = EN_REG ? ST_IDLE : ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d = EN_REG ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                // The slot is already served; never re-request it.
                if (EN_REG) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load buffer and MEM/WB register: next values
    // ------------------------------------------------------------------
    always_comb begin
        ldbuf_d    = ldbuf_q;
        wb_regD_d  = wb_regD_q;
        wb_we_d    = wb_we_q;
        wb_data_d  = wb_data_q;
        addr_err_d = 1'b0;

        if (w_ack && !w_store) begin
            ldbuf_d = dmem_rdata;
        end

        if (w_commit) begin
            wb_regD_d  = regD_in;
            wb_we_d    = WB_EN_in & ~w_misaligned;
            wb_data_d  = MEM_TO_REG_in ? w_load_data : alu_result;
            addr_err_d = w_misaligned;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ldbuf_q    <= 32'd0;
            wb_regD_q  <= 5'd0;
            wb_we_q    <= 1'b0;
            wb_data_q  <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ldbuf_q    <= ldbuf_d;
            wb_regD_q  <= wb_regD_d;
            wb_we_q    <= wb_we_d;
            wb_data_q  <= wb_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dmem_req   = w_req;
    assign dmem_we    = w_req & w_store;
    assign dmem_addr  = w_req ? w_addr : '0;
    assign dmem_wdata = w_req ? store_data : 32'd0;
    assign stall_mem  = w_stall;

    assign branch_taken  = is_BRANCH_in & zero_in;
    assign branch_target = PCNEXT_in;

    assign mem_regD    = regD_in;
    assign RegW_en_mem = WB_EN_in;
    assign regFromMem  = alu_result;

    assign wb_regD    = wb_regD_q;
    assign RegW_en_wb = wb_we_q;
    assign regFromWB  = wb_data_q;
    assign addr_err   = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. Stimulus pushes the
//               expected MEM/WB contents of every committing slot into a
//               queue; a monitor pops and compares after each commit edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EN_REG, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, MEM_TO_REG_in;
    logic        is_BRANCH_in, zero_in;
    logic [4:0]  regD_in;
    logic [31:0] alu_result, store_data, PCNEXT_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack, stall_mem, branch_taken;
    logic [31:0] branch_target;
    logic [4:0]  mem_regD, wb_regD;
    logic        RegW_en_mem, RegW_en_wb, addr_err;
    logic [31:0] regFromMem, regFromWB;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .EN_REG(EN_REG),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .MEM_TO_REG_in(MEM_TO_REG_in), .is_BRANCH_in(is_BRANCH_in), .zero_in(zero_in),
        .regD_in(regD_in), .alu_result(alu_result), .store_data(store_data),
        .PCNEXT_in(PCNEXT_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall_mem(stall_mem), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_regD(mem_regD), .RegW_en_mem(RegW_en_mem),
        .regFromMem(regFromMem), .wb_regD(wb_regD), .RegW_en_wb(RegW_en_wb),
        .regFromWB(regFromWB), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic wb, input logic [4:0] rd,
                         input logic rd_en, input logic wr_en, input logic m2r,
                         input logic br, input logic z, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [31:0] pcn,
                         input logic ack, input logic [31:0] rdata);
        EN_REG = en; WB_EN_in = wb; regD_in = rd;
        MEM_R_EN_in = rd_en; MEM_W_EN_in = wr_en; MEM_TO_REG_in = m2r;
        is_BRANCH_in = br; zero_in = z; alu_result = alu; store_data = sd;
        PCNEXT_in = pcn; dmem_ack = ack; dmem_rdata = rdata;
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic we,
                                input logic [31:0] data, input logic err);
        exp_t e;
        e.rd = rd; e.we = we; e.data = data; e.err = err;
        return e;
    endfunction

    // Monitor: a commit is an edge with reset released, EN_REG high and no
    // stall. Otherwise addr_err must read 0 after the edge.
    initial begin : monitor
        logic c;
        exp_t e, got;
        forever begin
            @(posedge clk);
            c = reset && EN_REG && !stall_mem;
            #1;
            got = mk(wb_regD, RegW_en_wb, regFromWB, addr_err);
            tests_run++;
            if (c) begin
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wb_unexpected: got %h, expected no commit", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        tests_failed++;
                        $display("FAIL wb_commit: got rd=%0d we=%0b data=0x%08h err=%0b, expected rd=%0d we=%0b data=0x%08h err=%0b",
                                 got.rd, got.we, got.data, got.err, e.rd, e.we, e.data, e.err);
                    end
                end
            end else if (addr_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL addr_err_idle: got %0b, expected 0", addr_err);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int stall_cnt;
        int req_cnt;

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_req", {31'd0, dmem_req}, 0);
        chk("rst_stall", {31'd0, stall_mem}, 0);
        chk("rst_wb_regD", {27'd0, wb_regD}, 0);
        chk("rst_wb_we", {31'd0, RegW_en_wb}, 0);
        chk("rst_wb_data", regFromWB, 0);
        chk("rst_addr_err", {31'd0, addr_err}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Non-memory op passes through in one cycle
        @(negedge clk);
        drive(1, 1, 5, 0, 0, 0, 0, 0, 32'h2A, 0, 0, 0, 0);
        exp_q.push_back(mk(5, 1, 32'h2A, 0));
        #1;
        chk("nop_req", {31'd0, dmem_req}, 0);
        chk("nop_stall", {31'd0, stall_mem}, 0);
        chk("fwd_data", regFromMem, 32'h2A);
        chk("fwd_regD", {27'd0, mem_regD}, 5);
        chk("fwd_we", {31'd0, RegW_en_mem}, 1);

        // Load at 0x100, three wait cycles
        @(negedge clk);
        drive(1, 1, 7, 1, 0, 1, 0, 0, 32'h100, 0, 0, 0, 0);
        exp_q.push_back(mk(7, 1, 32'hDEADBEEF, 0));
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_req_wait", {31'd0, dmem_req}, 1);
            chk("ld_addr_wait", dmem_addr, 32'h100);
            if (stall_mem) stall_cnt++;
            @(negedge clk);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_stall_ack", {31'd0, stall_mem}, 0);
        chk("ld_addr_ack", dmem_addr, 32'h100);
        chk("ld_stall_cycles", stall_cnt, 3);

        // Zero-wait store at 0x204
        @(negedge clk);
        drive(1, 0, 8, 0, 1, 0, 0, 0, 32'h204, 32'h12345678, 0, 1, 0);
        exp_q.push_back(mk(8, 0, 32'h204, 0));
        #1;
        chk("st_req", {31'd0, dmem_req}, 1);
        chk("st_we", {31'd0, dmem_we}, 1);
        chk("st_wdata", dmem_wdata, 32'h12345678);
        chk("st_addr", dmem_addr, 32'h204);
        chk("st_stall", {31'd0, stall_mem}, 0);

        // Misaligned load at 0x102
        @(negedge clk);
        drive(1, 1, 9, 1, 0, 0, 0, 0, 32'h102, 0, 0, 0, 0);
        exp_q.push_back(mk(9, 0, 32'h102, 1));
        #1;
        chk("mis_req", {31'd0, dmem_req}, 0);
        chk("mis_stall", {31'd0, stall_mem}, 0);
        chk("mis_addr", dmem_addr, 0);

        // Ack while EN_REG low for two cycles, then commit from DONE
        @(negedge clk);
        drive(0, 1, 3, 1, 0, 1, 0, 0, 32'h300, 0, 0, 1, 32'hCAFEF00D);
        exp_q.push_back(mk(3, 1, 32'hCAFEF00D, 0));
        req_cnt = 0;
        #1;
        chk("hold_stall_ack", {31'd0, stall_mem}, 0);
        if (dmem_req) req_cnt++;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h11111111;
        #1;
        chk("hold_done_stall", {31'd0, stall_mem}, 0);
        if (dmem_req) req_cnt++;
        @(negedge clk);
        EN_REG = 1'b1;
        #1;
        chk("hold_commit_stall", {31'd0, stall_mem}, 0);
        if (dmem_req) req_cnt++;
        chk("hold_req_count", req_cnt, 1);

        // Back-to-back zero-wait loads
        @(negedge clk);
        drive(1, 1, 10, 1, 0, 1, 0, 0, 32'h10, 0, 0, 1, 32'hA1A1A1A1);
        exp_q.push_back(mk(10, 1, 32'hA1A1A1A1, 0));
        #1;
        chk("b2b_req1", {31'd0, dmem_req}, 1);
        @(negedge clk);
        drive(1, 1, 11, 1, 0, 1, 0, 0, 32'h14, 0, 0, 1, 32'hB2B2B2B2);
        exp_q.push_back(mk(11, 1, 32'hB2B2B2B2, 0));
        #1;
        chk("b2b_req2", {31'd0, dmem_req}, 1);
        chk("b2b_addr2", dmem_addr, 32'h14);
        chk("b2b_stall", {31'd0, stall_mem}, 0);

        // Branch resolution
        @(negedge clk);
        drive(1, 0, 12, 0, 0, 0, 1, 1, 32'h55, 0, 32'h40, 0, 0);
        exp_q.push_back(mk(12, 0, 32'h55, 0));
        #1;
        chk("br_taken", {31'd0, branch_taken}, 1);
        chk("br_target", branch_target, 32'h40);
        @(negedge clk);
        zero_in = 1'b0;
        exp_q.push_back(mk(12, 0, 32'h55, 0));
        #1;
        chk("br_not_taken", {31'd0, branch_taken}, 0);

        // Reset pulsed during WAIT; a late ack must not commit anything
        @(negedge clk);
        drive(1, 1, 13, 1, 0, 1, 0, 0, 32'h400, 0, 0, 0, 0);
        #1;
        chk("rw_stall", {31'd0, stall_mem}, 1);
        @(negedge clk);
        #1;
        chk("rw_req_wait", {31'd0, dmem_req}, 1);
        reset = 1'b0;
        #1;
        chk("rw_req_drop", {31'd0, dmem_req}, 0);
        chk("rw_stall_drop", {31'd0, stall_mem}, 0);
        chk("rw_wb_regD", {27'd0, wb_regD}, 0);
        chk("rw_wb_we", {31'd0, RegW_en_wb}, 0);
        chk("rw_wb_data", regFromWB, 0);
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h99999999;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99999999);
        reset = 1'b1;
        #1;
        chk("late_ack_req", {31'd0, dmem_req}, 0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("late_ack_data", regFromWB, 0);
        chk("late_ack_we", {31'd0, RegW_en_wb}, 0);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
